// File: rtl/booth_mul_sched_if.sv
// Handshake bundle for booth_mul_sched: two operand requesters and one product consumer.
interface booth_mul_sched_if #(
  parameter int WIDTH = 4
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [WIDTH-1:0]       req0_x;
  logic [WIDTH-1:0]       req0_y;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [WIDTH-1:0]       req1_x;
  logic [WIDTH-1:0]       req1_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_z;
  logic                   out_id;

  modport master (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_z, out_id
  );

  modport slave (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_z, out_id
  );
endinterface

// File: rtl/booth_mul_sched.sv
// Radix-2 Booth multiplier (one multiplier bit per cycle) shared round-robin
// between two requesters. Optional zero-operand shortcut: define
// BOOTH_MUL_SCHED_ZERO_SKIP_EN to jump straight to DONE when x or y is zero.
module booth_mul_sched #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  booth_mul_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 id_q;
  logic [WIDTH:0]       acc_hi;     // upper half, one guard bit so -y of the most-negative y fits
  logic [WIDTH-1:0]     acc_lo;     // multiplier bits, shifted out LSB first
  logic                 prev;       // Booth extra bit
  logic [WIDTH:0]       y_ext;
  logic [CW-1:0]        cnt;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   out_z_q;
  logic                 out_id_q;

  logic                 grant1;
  logic                 req_any;
  logic                 accept;
  logic [WIDTH-1:0]     sel_x;
  logic [WIDTH-1:0]     sel_y;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;

  // Round-robin arbitration; readys only in IDLE and never during reset
  always_comb begin
    grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant);
    req_any = bus.req0_valid || bus.req1_valid;
    accept  = (state == IDLE) && !rst && req_any;
    sel_x   = grant1 ? bus.req1_x : bus.req0_x;
    sel_y   = grant1 ? bus.req1_y : bus.req0_y;
  end

  assign bus.req0_ready = accept && !grant1;
  assign bus.req1_ready = accept && grant1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_z      = out_z_q;
  assign bus.out_id     = out_id_q;

  // One Booth step: recode {x[i], prev}, add to upper half, then arithmetic shift right
  always_comb begin
    sum = acc_hi;
    case ({acc_lo[0], prev})
      2'b10:   sum = acc_hi - y_ext;
      2'b01:   sum = acc_hi + y_ext;
      default: sum = acc_hi;
    endcase
    shifted = {sum[WIDTH], sum, acc_lo[WIDTH-1:1]};
  end

  // Scheduler FSM with registered product outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      prev        <= 1'b0;
      y_ext       <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            id_q       <= grant1;
            last_grant <= grant1;
            acc_hi     <= '0;
            acc_lo     <= sel_x;
            prev       <= 1'b0;
            y_ext      <= {sel_y[WIDTH-1], sel_y};
            cnt        <= '0;
`ifdef BOOTH_MUL_SCHED_ZERO_SKIP_EN
            if (sel_x == '0 || sel_y == '0) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_z_q     <= '0;
              out_id_q    <= grant1;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          acc_hi <= shifted[2*WIDTH:WIDTH];
          acc_lo <= shifted[WIDTH-1:0];
          prev   <= acc_lo[0];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_z_q     <= shifted[2*WIDTH-1:0];
            out_id_q    <= id_q;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched (WIDTH=4) with a behavioural product/arbiter model.
module tb_booth_mul_sched;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  booth_mul_sched_if #(.WIDTH(W)) bus ();

  booth_mul_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Cycles from accept edge to first out_valid sample (1 = cycle right after accept)
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_MUL_SCHED_ZERO_SKIP_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Present operands; returns one time unit after the accept edge with the granted id
  task automatic issue(input logic v0, input logic v1,
                       input logic [W-1:0] x0, input logic [W-1:0] y0,
                       input logic [W-1:0] x1, input logic [W-1:0] y1,
                       output logic gid, output logic to);
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1;
    to = 1'b1;
    gid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready;
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      @(posedge clk); #1;
      if (gid) begin
        bus.req1_valid = 1'b0; bus.req1_x = W'($urandom); bus.req1_y = W'($urandom);
      end else begin
        bus.req0_valid = 1'b0; bus.req0_x = W'($urandom); bus.req0_y = W'($urandom);
      end
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_x = 4'h3; bus.req0_y = 4'h3; bus.req1_x = 4'h2; bus.req1_y = 4'h2;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_readys got=%b exp=00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_z !== 8'h00) begin
      failures++; $display("FAIL reset_out_z got=%h exp=00", bus.out_z);
    end
    checks++;
    if (bus.out_id !== 1'b0) begin
      failures++; $display("FAIL reset_out_id got=%b exp=0", bus.out_id);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic gid, to; int lat;
    bus.out_ready = 1'b1;
    issue(1'b1, 1'b0, 4'h3, 4'hE, 4'h0, 4'h0, gid, to);
    checks++;
    if ({to, gid} !== 2'b00) begin
      failures++; $display("FAIL basic_grant got to=%b id=%b exp to=0 id=0", to, gid);
    end
    wait_out(lat);
    checks++;
    if (lat !== W + 1) begin
      failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1);
    end
    checks++;
    if ({bus.out_z, bus.out_id} !== {8'hFA, 1'b0}) begin
      failures++; $display("FAIL basic_product got z=%h id=%b exp z=fa id=0", bus.out_z, bus.out_id);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_one_cycle got=%b exp=0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_tie();
    logic gid, to; int lat;
    pulse_reset();
    issue(1'b1, 1'b1, 4'h8, 4'h8, 4'h7, 4'h8, gid, to);
    checks++;
    if ({to, gid} !== 2'b00) begin
      failures++; $display("FAIL tie_first_grant got to=%b id=%b exp to=0 id=0", to, gid);
    end
    wait_out(lat);
    checks++;
    if ({bus.out_z, bus.out_id, lat} !== {8'h40, 1'b0, W + 1}) begin
      failures++; $display("FAIL tie_first_product got z=%h id=%b lat=%0d exp z=40 id=0 lat=%0d",
                           bus.out_z, bus.out_id, lat, W + 1);
    end
    take();
    issue(1'b1, 1'b1, 4'h8, 4'h8, 4'h7, 4'h8, gid, to);
    bus.req0_valid = 1'b0;
    checks++;
    if ({to, gid} !== 2'b01) begin
      failures++; $display("FAIL tie_second_grant got to=%b id=%b exp to=0 id=1", to, gid);
    end
    wait_out(lat);
    checks++;
    if ({bus.out_z, bus.out_id, lat} !== {8'hC8, 1'b1, W + 1}) begin
      failures++; $display("FAIL tie_second_product got z=%h id=%b lat=%0d exp z=c8 id=1 lat=%0d",
                           bus.out_z, bus.out_id, lat, W + 1);
    end
    take();
  endtask

  task automatic test_stall();
    logic gid, to; int lat;
    logic [2*W-1:0] ez;
    ez = ref_mul(4'h5, 4'hD);
    issue(1'b1, 1'b0, 4'h5, 4'hD, 4'h0, 4'h0, gid, to);
    wait_out(lat);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_z, bus.out_id, bus.req0_ready, bus.req1_ready} !== {1'b1, ez, 1'b0, 2'b00}) begin
        failures++; $display("FAIL stall_hold cyc=%0d got v=%b z=%h id=%b r=%b%b exp v=1 z=%h id=0 r=00",
                             i, bus.out_valid, bus.out_z, bus.out_id, bus.req0_ready, bus.req1_ready, ez);
      end
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL stall_handshake_readys got=%b%b exp=00", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release got=%b exp=0", bus.out_valid);
    end
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++; $display("FAIL stall_idle_ready got=%b exp=1", bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    logic gid, to; int lat;
    logic seen;
    bus.out_ready = 1'b1;
    issue(1'b1, 1'b0, 4'h6, 4'h5, 4'h0, 4'h0, gid, to);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL rstbusy_readys got=%b%b exp=00", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rstbusy_abandon got out_valid seen=%b exp=0", seen);
    end
    issue(1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, gid, to);
    wait_out(lat);
    checks++;
    if ({to, bus.out_valid, bus.out_z, bus.out_id} !== {1'b0, 1'b1, 8'h01, 1'b0}) begin
      failures++; $display("FAIL rstbusy_next got to=%b v=%b z=%h id=%b exp to=0 v=1 z=01 id=0",
                           to, bus.out_valid, bus.out_z, bus.out_id);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero();
    logic gid, to; int lat;
    issue(1'b1, 1'b0, 4'h0, 4'h5, 4'h0, 4'h0, gid, to);
    wait_out(lat);
    checks++;
    if ({bus.out_z, lat} !== {8'h00, exp_lat(4'h0, 4'h5)}) begin
      failures++; $display("FAIL zero_operand got z=%h lat=%0d exp z=00 lat=%0d", bus.out_z, lat, exp_lat(4'h0, 4'h5));
    end
    take();
  endtask

  task automatic test_exhaustive();
    logic gid, to; int lat;
    logic [7:0] idx;
    logic [W-1:0] a, b;
    logic id;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      a = idx[7:4];
      b = idx[3:0];
      id = idx[0];
      issue(!id, id, a, b, a, b, gid, to);
      wait_out(lat);
      checks++;
      if ({to, gid, bus.out_z, bus.out_id, lat} !== {1'b0, id, ref_mul(a, b), id, exp_lat(a, b)}) begin
        failures++; $display("FAIL exhaustive x=%h y=%h got to=%b g=%b z=%h id=%b lat=%0d exp z=%h id=%b lat=%0d",
                             a, b, to, gid, bus.out_z, bus.out_id, lat, ref_mul(a, b), id, exp_lat(a, b));
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    logic gid, to; int lat;
    logic v0, v1, model_last, eg;
    logic [W-1:0] x0, y0, x1, y1, ex, ey;
    int stall;
    pulse_reset();
    model_last = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
      eg = (v0 && v1) ? !model_last : v1;
      ex = eg ? x1 : x0;
      ey = eg ? y1 : y0;
      issue(v0, v1, x0, y0, x1, y1, gid, to);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_out(lat);
      checks++;
      if ({to, gid, bus.out_z, bus.out_id, lat} !== {1'b0, eg, ref_mul(ex, ey), eg, exp_lat(ex, ey)}) begin
        failures++; $display("FAIL rr it=%0d got to=%b g=%b z=%h id=%b lat=%0d exp g=%b z=%h lat=%0d",
                             i, to, gid, bus.out_z, bus.out_id, lat, eg, ref_mul(ex, ey), exp_lat(ex, ey));
      end
      model_last = eg;
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
      end
      take();
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req1_x = '0; bus.req1_y = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_stall();
    test_reset_busy();
    test_zero();
    test_exhaustive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (signed, two's complement); WIDTH >= 2 SHALL be supported.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-005 Port: req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-006 Port: req0_x, req0_y  input  WIDTH each  requester 0 signed multiplier and multiplicand.
REQ-007 Port: req1_valid, req1_ready, req1_x, req1_y  SHALL mirror REQ-004..REQ-006 for requester 1.
REQ-008 Port: out_valid  output  1  product available.
REQ-009 Port: out_ready  input  1  consumer accepts product.
REQ-010 Port: out_z  output  2*WIDTH  signed product.
REQ-011 Port: out_id  output  1  requester index (0/1) that owns out_z.

Function
REQ-012 The block SHALL share one radix-2 Booth datapath (one multiplier bit per cycle) between two requesters.
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE: reqN_ready SHALL be 1 combinationally for exactly the granted requester when any reqN_valid is 1; otherwise both readys 0.
REQ-015 Arbitration: single valid -> that requester granted; both valid -> requester other than last_grant granted (round-robin).
REQ-016 On accept (valid & ready): latch x, y, id; update last_grant; clear accumulator and Booth extra bit; go BUSY.
REQ-017 BUSY: each cycle examine {x[i], prev}: 10 -> add -y to upper half, 01 -> add +y, 00/11 -> none; then arithmetic shift right by 1; iterate i = 0..WIDTH-1.
REQ-018 After exactly WIDTH BUSY cycles -> DONE; accept at edge T -> out_valid 1 from cycle T+WIDTH+1.
REQ-019 out_z SHALL equal the exact signed product x*y in 2*WIDTH bits, including x = y = most-negative value (WIDTH=4: -8*-8 = 8'h40).
REQ-020 DONE: out_valid, out_z, out_id held stable until out_ready = 1; then -> IDLE next cycle.
REQ-021 No bypass: a new request SHALL be accepted no earlier than the cycle after the DONE handshake.
REQ-022 Both readys SHALL be 0 in BUSY and DONE; reqN_x/y may change freely after accept.
REQ-023 out_ready while out_valid = 0 SHALL be ignored.
REQ-024 out_valid SHALL be 0 in IDLE and BUSY.

Reset
REQ-025 rst = 1 at a clock edge: state -> IDLE, out_valid = 0, out_z = 0, out_id = 0, last_grant = 1 (requester 0 wins first tie).
REQ-026 Reset in BUSY or DONE SHALL abandon the operation; no product for it SHALL ever be presented.
REQ-027 Readys SHALL be 0 in any cycle where rst = 1.

Configuration
REQ-028 Macro BOOTH_MUL_SCHED_ZERO_SKIP_EN defined: if latched x = 0 or y = 0, FSM SHALL go IDLE -> DONE directly, out_z = 0, out_valid 1 from cycle T+1.
REQ-029 Macro undefined: all operands, including zero, SHALL take the full WIDTH BUSY cycles (REQ-018).

Verification
REQ-030 WIDTH=4, req0 only x=3 y=-2, out_ready=1 -> out_z=8'hFA (-6), out_id=0, out_valid at T+5 for one cycle.
REQ-031 After reset, both valid same cycle (req0 x=-8 y=-8, req1 x=7 y=-8), held -> req0 granted first, out_z=8'h40 id 0; then req1, out_z=8'hC8 (-56) id 1.
REQ-032 out_ready=0 for 10 cycles in DONE -> out_valid/out_z/out_id stable, both readys 0; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed in 2nd BUSY cycle -> out_valid never asserts for that request; next request (x=-1 y=-1) yields out_z=8'h01.
REQ-034 x=0 y=5: with BOOTH_MUL_SCHED_ZERO_SKIP_EN out_valid at T+1, out_z=0; without, out_valid at T+5, out_z=0.
REQ-035 Exhaustive WIDTH=4: all 256 (x,y) pairs alternating requesters -> every out_z matches signed reference product and correct out_id.
